branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage pipeline. It looks up the fetch PC each cycle in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and drives the prediction carried down to execute. It takes the resolved branch outcome back from the execute stage, updates its tables, and generates the misprediction redirect and flush. It also keeps branch and misprediction statistics counters.

## Interface
- ENTRIES, 16: number of BTB entries; power of two, at least 2.
- INDEX_BITS, 4: log2(ENTRIES). Index is PC[INDEX_BITS+1:2]; tag is PC[31:INDEX_BITS+2].
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- PCF  input  32  fetch-stage PC.
- PredictTakenF  output  1  prediction for PCF: BTB hit and counter[1]=1.
- PredictedPCF  output  32  the stored target when PredictTakenF=1, otherwise PCF+4.
- BranchE  input  1  a conditional branch is resolving in execute this cycle.
- KillE  input  1  the instruction in execute is squashed; suppresses update, statistics and mispredict.
- PCE  input  32  PC of the branch in execute.
- TakenE  input  1  actual outcome (PCSrcE).
- PCTargetE  input  32  actual branch target.
- PredictionE  input  1  PredictTakenF value that travelled with this branch.
- PredictedPCE  input  32  PredictedPCF value that travelled with this branch.
- MispredictE  output  1  redirect fetch and flush the IF/ID and ID/EX stages.
- RedirectPCE  output  32  correct next PC: PCTargetE if TakenE, otherwise PCE+4.
- BranchCount  output  32  number of resolved branches, saturating at 0xFFFFFFFF.
- MispredictCount  output  32  number of mispredictions, saturating at 0xFFFFFFFF.

## Operation
- Each entry holds: valid (1 bit), tag (32-INDEX_BITS-2 bits), target (32 bits), ctr (2 bits: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
- Lookup is combinational:
  - hit = valid[idx] & (tag[idx] == PCF tag).
  - PredictTakenF = hit & ctr[idx][1].
- A branch is valid when V = BranchE & ~KillE.
- MispredictE = V & ((TakenE != PredictionE) | (TakenE & PredictionE & (PredictedPCE != PCTargetE))).
  - MispredictE and RedirectPCE are combinational from the E inputs.
  - RedirectPCE is always computed; it is meaningful only when MispredictE=1.
- Update at posedge clk when V=1, using the PCE index and tag. "Hit" here means the PCE lookup:
  - Taken and hit: target <= PCTargetE; ctr <= sat_inc(ctr).
  - Taken and miss: allocate (overwrite) with valid=1, tag, target=PCTargetE, ctr=10.
  - Not taken and hit: ctr <= sat_dec(ctr); target unchanged.
  - Not taken and miss: no change (no allocation on not-taken).
- Saturation: ctr 11 stays 11 on taken; ctr 00 stays 00 on not-taken.
- Statistics, when V=1: BranchCount +1; MispredictCount +1 if MispredictE. Both hold at max.
- PC+4 additions are modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).

## Timing
- Reset (asynchronous, takes effect immediately on assertion):
  - every valid=0, ctr=01, target=0, tag=0;
  - both statistics counters = 0.
  - Therefore PredictTakenF=0 and PredictedPCF=PCF+4 while and after reset.
- While rst=1 the tables and counters hold their reset values; no update occurs even if V=1.
- Lookup latency: 0 cycles (combinational from PCF).
- Update latency: 1 cycle. A table write at edge N is visible to a lookup from cycle N+1.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents; there is no bypass.
- MispredictE is a single-cycle pulse per mispredicted branch; it has no state.

## Test plan
- Reset, PCF=0x100 -> PredictTakenF=0, PredictedPCF=0x104, BranchCount=0, MispredictCount=0.
- Branch at PCE=0x100 resolves taken to 0x80 with PredictionE=0 -> MispredictE=1, RedirectPCE=0x80, MispredictCount=1. Next cycle, PCF=0x100 -> PredictTakenF=1, PredictedPCF=0x80.
- Same branch resolves not-taken twice (PredictionE=1, PredictedPCE=0x80):
  - first -> MispredictE=1, RedirectPCE=0x104, ctr 10->01;
  - second -> ctr 01->00.
  - Lookup of 0x100 then gives PredictTakenF=0.
- Aliasing (ENTRIES=16): taken branch at 0x140 (index 0, different tag) overwrites the 0x100 entry. Lookup of 0x100 -> miss, PredictedPCF=0x104.
- Target change: PredictionE=1, PredictedPCE=0x80, TakenE=1, PCTargetE=0x90 -> MispredictE=1, RedirectPCE=0x90, stored target becomes 0x90.
- KillE=1 with BranchE=1 and a mismatching outcome -> MispredictE=0, no table change, counters unchanged.
- Asynchronous rst asserted mid-sequence with a populated BTB -> all lookups miss immediately and both counters read 0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters.
// Lookup of the fetch PC is combinational. Resolved branches from execute
// update the table one cycle later. The block also produces the mispredict
// redirect and keeps saturating branch and mispredict statistics.
module branch_predictor #(
  parameter int ENTRIES    = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredictTakenF,
  output logic [31:0] PredictedPCF,
  input  logic        BranchE,
  input  logic        KillE,
  input  logic [31:0] PCE,
  input  logic        TakenE,
  input  logic [31:0] PCTargetE,
  input  logic        PredictionE,
  input  logic [31:0] PredictedPCE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);

  localparam int TAG_W = 32 - INDEX_BITS - 2;

  // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  localparam logic [1:0] CTR_RESET = 2'b01;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  // Saturating increment of a 2-bit prediction counter.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  // Saturating decrement of a 2-bit prediction counter.
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_cnt(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // BTB storage
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispred_cnt;

  // Fetch-side lookup fields
  logic [INDEX_BITS-1:0] w_idx_f;
  logic [TAG_W-1:0]      w_tag_f;
  logic                  w_hit_f;
  logic [31:0]           w_pcf_plus4;

  // Execute-side lookup / resolution fields
  logic [INDEX_BITS-1:0] w_idx_e;
  logic [TAG_W-1:0]      w_tag_e;
  logic                  w_hit_e;
  logic                  w_valid_e;
  logic [31:0]           w_pce_plus4;

  // The low two PC bits never select anything (word-aligned instructions).
  logic w_unused_pc_lsbs;
  assign w_unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

  assign w_idx_f     = PCF[INDEX_BITS+1:2];
  assign w_tag_f     = PCF[31:INDEX_BITS+2];
  assign w_pcf_plus4 = PCF + 32'd4;

  assign w_idx_e     = PCE[INDEX_BITS+1:2];
  assign w_tag_e     = PCE[31:INDEX_BITS+2];
  assign w_pce_plus4 = PCE + 32'd4;

  assign w_valid_e   = BranchE & ~KillE;

  // Fetch prediction: reads the pre-update table contents (no write bypass).
  always_comb begin
    w_hit_f       = r_valid[w_idx_f] & (r_tag[w_idx_f] == w_tag_f);
    PredictTakenF = w_hit_f & r_ctr[w_idx_f][1];
    PredictedPCF  = PredictTakenF ? r_target[w_idx_f] : w_pcf_plus4;
  end

  // Execute resolution: detect wrong direction or wrong taken target.
  always_comb begin
    w_hit_e     = r_valid[w_idx_e] & (r_tag[w_idx_e] == w_tag_e);
    MispredictE = w_valid_e &
                  ((TakenE != PredictionE) |
                   (TakenE & PredictionE & (PredictedPCE != PCTargetE)));
    RedirectPCE = TakenE ? PCTargetE : w_pce_plus4;
  end

  // BTB update: train on hits, allocate only on taken misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RESET;
      end
    end else if (w_valid_e) begin
      if (TakenE) begin
        if (w_hit_e) begin
          r_target[w_idx_e] <= PCTargetE;
          r_ctr[w_idx_e]    <= sat_inc(r_ctr[w_idx_e]);
        end else begin
          r_valid[w_idx_e]  <= 1'b1;
          r_tag[w_idx_e]    <= w_tag_e;
          r_target[w_idx_e] <= PCTargetE;
          r_ctr[w_idx_e]    <= CTR_ALLOC;
        end
      end else if (w_hit_e) begin
        r_ctr[w_idx_e] <= sat_dec(r_ctr[w_idx_e]);
      end
    end
  end

  // Statistics: count every live resolved branch and its mispredictions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_valid_e) begin
      r_branch_cnt <= sat_cnt(r_branch_cnt);
      if (MispredictE) begin
        r_mispred_cnt <= sat_cnt(r_mispred_cnt);
      end
    end
  end

  assign BranchCount     = r_branch_cnt;
  assign MispredictCount = r_mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor. Each vector is held for
// one clock; outputs are sampled at the falling edge, i.e. before the rising
// edge that commits the vector's update, so table and counter expectations
// reflect the state left by the previous vectors.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredictTakenF;
  logic [31:0] PredictedPCF;
  logic        BranchE;
  logic        KillE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] PCTargetE;
  logic        PredictionE;
  logic [31:0] PredictedPCE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.ENTRIES(16), .INDEX_BITS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .PCF             (PCF),
    .PredictTakenF   (PredictTakenF),
    .PredictedPCF    (PredictedPCF),
    .BranchE         (BranchE),
    .KillE           (KillE),
    .PCE             (PCE),
    .TakenE          (TakenE),
    .PCTargetE       (PCTargetE),
    .PredictionE     (PredictionE),
    .PredictedPCE    (PredictedPCE),
    .MispredictE     (MispredictE),
    .RedirectPCE     (RedirectPCE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pcf;
    logic        br;
    logic        kill;
    logic [31:0] pce;
    logic        tk;
    logic [31:0] tgt;
    logic        pred;
    logic [31:0] ppce;
    logic        e_ptf;
    logic [31:0] e_ppcf;
    logic        e_mis;
    logic [31:0] e_redir;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [31:0] pcf, input logic br, input logic kill,
    input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
    input logic pred, input logic [31:0] ppce,
    input logic e_ptf, input logic [31:0] e_ppcf, input logic e_mis,
    input logic [31:0] e_redir, input logic [31:0] e_bc, input logic [31:0] e_mc);
    vec_t v;
    v.pcf = pcf; v.br = br; v.kill = kill; v.pce = pce; v.tk = tk;
    v.tgt = tgt; v.pred = pred; v.ppce = ppce;
    v.e_ptf = e_ptf; v.e_ppcf = e_ppcf; v.e_mis = e_mis;
    v.e_redir = e_redir; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  // Lookup-only cycle: no branch in execute, so PCE=0 gives redirect 4.
  function automatic vec_t look(
    input logic [31:0] pcf, input logic e_ptf, input logic [31:0] e_ppcf,
    input logic [31:0] e_bc, input logic [31:0] e_mc);
    return mk(pcf, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
              e_ptf, e_ppcf, 1'b0, 32'h4, e_bc, e_mc);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    PCF = v.pcf; BranchE = v.br; KillE = v.kill; PCE = v.pce; TakenE = v.tk;
    PCTargetE = v.tgt; PredictionE = v.pred; PredictedPCE = v.ppce;
  endtask

  task automatic idle_e();
    BranchE = 1'b0; KillE = 1'b0; PCE = 32'h0; TakenE = 1'b0;
    PCTargetE = 32'h0; PredictionE = 1'b0; PredictedPCE = 32'h0;
  endtask

  initial begin
    //           pcf          br kill pce          tk tgt          pred ppce          ptf ppcf         mis redir        bc      mc
    vecs.push_back(look(32'h100, 0, 32'h104, 0, 0));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 0, 0)); // first taken, no bypass
    vecs.push_back(look(32'h100, 1, 32'h80, 1, 1));                                               // allocated ctr=10
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h80, 1, 32'h80, 1, 32'h80, 1, 32'h104, 1, 1)); // NT: 10->01
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h80, 0, 32'h104, 0, 32'h104, 0, 32'h104, 2, 2)); // NT: 01->00
    vecs.push_back(look(32'h100, 0, 32'h104, 3, 2));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h104, 0, 32'h104, 3, 2)); // 00 stays 00
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 4, 2)); // hit: 00->01
    vecs.push_back(look(32'h100, 0, 32'h104, 5, 3));                                              // still weak NT
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 5, 3)); // 01->10
    vecs.push_back(look(32'h100, 1, 32'h80, 6, 4));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h90, 1, 32'h80, 1, 32'h80, 1, 32'h90, 6, 4));  // target change, 10->11
    vecs.push_back(look(32'h100, 1, 32'h90, 7, 5));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h90, 1, 32'h90, 1, 32'h90, 0, 32'h90, 7, 5));  // correct, 11 stays 11
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h90, 1, 32'h90, 1, 32'h90, 1, 32'h104, 8, 5)); // NT: 11->10
    vecs.push_back(look(32'h100, 1, 32'h90, 9, 6));
    vecs.push_back(mk(32'h100, 1, 1, 32'h100, 0, 32'h90, 1, 32'h90, 1, 32'h90, 0, 32'h104, 9, 6)); // killed
    vecs.push_back(look(32'h100, 1, 32'h90, 9, 6));                                               // untouched
    vecs.push_back(mk(32'h140, 1, 0, 32'h140, 1, 32'h200, 0, 32'h144, 0, 32'h144, 1, 32'h200, 9, 6)); // alias
    vecs.push_back(look(32'h100, 0, 32'h104, 10, 7));                                             // evicted
    vecs.push_back(look(32'h140, 1, 32'h200, 10, 7));
    vecs.push_back(mk(32'h208, 1, 0, 32'h208, 0, 32'h0, 0, 32'h20C, 0, 32'h20C, 0, 32'h20C, 10, 7)); // NT miss
    vecs.push_back(mk(32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40,
                      0, 32'h0, 1, 32'h0, 11, 7));                                                 // PC+4 wrap
    vecs.push_back(look(32'h140, 1, 32'h200, 12, 8));

    // Reset state, checked while rst is held.
    rst = 1'b1;
    PCF = 32'h100;
    idle_e();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ptf",  {31'h0, PredictTakenF}, 32'h0);
    check("rst_ppcf", PredictedPCF,           32'h104);
    check("rst_bc",   BranchCount,            32'h0);
    check("rst_mc",   MispredictCount,        32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d_ptf", i),   {31'h0, PredictTakenF}, {31'h0, vecs[i].e_ptf});
      check($sformatf("v%0d_ppcf", i),  PredictedPCF,           vecs[i].e_ppcf);
      check($sformatf("v%0d_mis", i),   {31'h0, MispredictE},   {31'h0, vecs[i].e_mis});
      check($sformatf("v%0d_redir", i), RedirectPCE,            vecs[i].e_redir);
      check($sformatf("v%0d_bc", i),    BranchCount,            vecs[i].e_bc);
      check($sformatf("v%0d_mc", i),    MispredictCount,        vecs[i].e_mc);
    end

    // Asynchronous reset mid-cycle with entry 0 populated (0x140 -> 0x200).
    @(posedge clk);
    #1;
    idle_e();
    PCF = 32'h140;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ptf",  {31'h0, PredictTakenF}, 32'h0);
    check("arst_ppcf", PredictedPCF,           32'h144);
    check("arst_bc",   BranchCount,            32'h0);
    check("arst_mc",   MispredictCount,        32'h0);

    // A live branch while reset is held must not train or count.
    BranchE = 1'b1; PCE = 32'h140; TakenE = 1'b1; PCTargetE = 32'h300;
    PredictionE = 1'b0; PredictedPCE = 32'h144;
    @(posedge clk);
    #1;
    check("hold_bc", BranchCount, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_e();
    #1;
    check("hold_ptf", {31'h0, PredictTakenF}, 32'h0);
    check("hold_mc",  MispredictCount,        32'h0);

    // First branch after reset release trains and counts normally.
    BranchE = 1'b1; PCE = 32'h140; TakenE = 1'b1; PCTargetE = 32'h300;
    PredictionE = 1'b0; PredictedPCE = 32'h144;
    #1;
    check("post_mis", {31'h0, MispredictE}, 32'h1);
    @(posedge clk);
    #1;
    idle_e();
    @(negedge clk);
    check("post_ptf",  {31'h0, PredictTakenF}, 32'h1);
    check("post_ppcf", PredictedPCF,           32'h300);
    check("post_bc",   BranchCount,            32'h1);
    check("post_mc",   MispredictCount,        32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
